// File: rtl/prog_table_fsm_if.sv
// Bus bundle for the table-driven sequencer: step control, status and table-write port.
// There is no handshake: en and cfg_we are single-cycle qualifiers sampled on each rising clk edge.
interface prog_table_fsm_if #(
   parameter int SW = 3,
   parameter int IW = 1,
   parameter int OW = 3,
   parameter int CW = 8
);
   logic             en;
   logic [IW-1:0]    in;
   logic [OW-1:0]    out;
   logic [SW-1:0]    state;
   logic             err;
   logic             clr_err;
   logic             cfg_we;
   logic [SW+IW-1:0] cfg_addr;
   logic [SW-1:0]    cfg_next;
   logic [OW-1:0]    cfg_out;
   logic             cfg_valid;
   logic [CW-1:0]    trans_cnt;

   modport master (
      output en, in, clr_err, cfg_we, cfg_addr, cfg_next, cfg_out, cfg_valid,
      input  out, state, err, trans_cnt
   );

   modport slave (
      input  en, in, clr_err, cfg_we, cfg_addr, cfg_next, cfg_out, cfg_valid,
      output out, state, err, trans_cnt
   );
endinterface

// File: rtl/prog_table_fsm.sv
// Run-time-programmable sequencer: the current state is looked up with the condition
// input in a writable table of {valid, next, out}.
module prog_table_fsm #(
   parameter int          SW          = 3,
   parameter int          IW          = 1,
   parameter int          OW          = 3,
   parameter int          CW          = 8,
   parameter logic [SW-1:0] RESET_STATE = '0,
   parameter logic [OW-1:0] DEFAULT_OUT = '0,
   parameter bit          REG_OUT     = 1'b0
) (
   input logic              clk,
   input logic              reset,
   prog_table_fsm_if.slave  bus
);
   localparam int AW = SW + IW;
   localparam int N  = 1 << AW;

   logic [N-1:0]  valid_q;
   logic [SW-1:0] next_mem [N];
   logic [OW-1:0] outv_mem [N];

   logic [SW-1:0] state_q;
   logic          err_q;
   logic [CW-1:0] cnt_q;
   logic [OW-1:0] out_q;

   logic [AW-1:0] addr;
   logic          e_valid;
   logic [SW-1:0] e_next;
   logic [OW-1:0] out_comb;

   always_comb begin
      addr     = {bus.in, state_q};
      e_valid  = valid_q[addr];
      e_next   = next_mem[addr];
      out_comb = e_valid ? outv_mem[addr] : DEFAULT_OUT;
   end

   // Only the valid bits are reset; payload fields keep stale content until rewritten.
   always_ff @(posedge clk) begin
      if (bus.cfg_we) begin
         next_mem[bus.cfg_addr] <= bus.cfg_next;
         outv_mem[bus.cfg_addr] <= bus.cfg_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RESET_STATE;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         valid_q <= '0;
         out_q   <= DEFAULT_OUT;
      end else begin
         out_q <= out_comb;
         if (bus.cfg_we)
            valid_q[bus.cfg_addr] <= bus.cfg_valid;
         // The step reads the pre-edge entry, so a same-cycle write only affects later steps.
         if (bus.en) begin
            if (e_valid) begin
               state_q <= e_next;
               if (e_next != state_q)
                  cnt_q <= cnt_q + CW'(1);
            end else begin
               state_q <= RESET_STATE;
            end
         end
         if (bus.en && !e_valid)
            err_q <= 1'b1;
         else if (bus.clr_err)
            err_q <= 1'b0;
      end
   end

   assign bus.out       = REG_OUT ? out_q : out_comb;
   assign bus.state     = state_q;
   assign bus.err       = err_q;
   assign bus.trans_cnt = cnt_q;
endmodule

// File: tb/tb_prog_table_fsm.sv
// Directed bench: three sequencer instances (Mealy, registered-out, 2-bit counter)
// share one stimulus stream and are checked against hand-computed values.
module tb_prog_table_fsm;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       en, clr_err, cfg_we, cfg_valid, in_v;
   logic [3:0] cfg_addr;
   logic [2:0] cfg_next, cfg_out;

   int n_cmp = 0;
   int n_err = 0;

   prog_table_fsm_if #(.SW(3), .IW(1), .OW(3), .CW(8)) bus_a ();
   prog_table_fsm_if #(.SW(3), .IW(1), .OW(3), .CW(8)) bus_b ();
   prog_table_fsm_if #(.SW(3), .IW(1), .OW(3), .CW(2)) bus_c ();

   assign bus_a.en = en;        assign bus_b.en = en;        assign bus_c.en = en;
   assign bus_a.in = in_v;      assign bus_b.in = in_v;      assign bus_c.in = in_v;
   assign bus_a.clr_err = clr_err;   assign bus_b.clr_err = clr_err;   assign bus_c.clr_err = clr_err;
   assign bus_a.cfg_we = cfg_we;     assign bus_b.cfg_we = cfg_we;     assign bus_c.cfg_we = cfg_we;
   assign bus_a.cfg_addr = cfg_addr; assign bus_b.cfg_addr = cfg_addr; assign bus_c.cfg_addr = cfg_addr;
   assign bus_a.cfg_next = cfg_next; assign bus_b.cfg_next = cfg_next; assign bus_c.cfg_next = cfg_next;
   assign bus_a.cfg_out = cfg_out;   assign bus_b.cfg_out = cfg_out;   assign bus_c.cfg_out = cfg_out;
   assign bus_a.cfg_valid = cfg_valid; assign bus_b.cfg_valid = cfg_valid; assign bus_c.cfg_valid = cfg_valid;

   prog_table_fsm #(.SW(3), .IW(1), .OW(3), .CW(8), .REG_OUT(1'b0)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave));
   prog_table_fsm #(.SW(3), .IW(1), .OW(3), .CW(8), .REG_OUT(1'b1)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave));
   prog_table_fsm #(.SW(3), .IW(1), .OW(3), .CW(2), .REG_OUT(1'b0)) dut_c (
      .clk(clk), .reset(reset), .bus(bus_c.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [2:0] nx, input logic [2:0] o,
                     input logic v);
      cfg_we = 1'b1; cfg_addr = a; cfg_next = nx; cfg_out = o; cfg_valid = v;
      tick();
      cfg_we = 1'b0;
   endtask

   initial begin
      int exp_s2 [7]  = '{0, 2, 5, 6, 4, 2, 5};
      int exp_o2 [7]  = '{2, 6, 5, 6, 4, 6, 5};
      int exp_ob2 [7] = '{2, 2, 6, 5, 6, 4, 6};
      int exp_c2 [7]  = '{0, 1, 2, 3, 0, 1, 2};
      int exp_s3 [6]  = '{5, 3, 6, 4, 2, 5};
      int exp_o3 [6]  = '{5, 5, 6, 4, 6, 5};
      int exp_c3 [6]  = '{2, 3, 0, 1, 2, 3};

      reset = 1'b0; en = 1'b0; in_v = 1'b0; clr_err = 1'b0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_next = '0; cfg_out = '0; cfg_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst state", 32'(bus_a.state), 0);
      chk("rst err", 32'(bus_a.err), 0);
      chk("rst cnt", 32'(bus_a.trans_cnt), 0);
      chk("rst out_a", 32'(bus_a.out), 0);
      chk("rst out_b", 32'(bus_b.out), 0);
      reset = 1'b1;

      // Empty table: every step traps
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t1 state[%0d]", i), 32'(bus_a.state), 0);
         chk($sformatf("t1 err[%0d]", i), 32'(bus_a.err), 1);
         chk($sformatf("t1 cnt[%0d]", i), 32'(bus_a.trans_cnt), 0);
         chk($sformatf("t1 out[%0d]", i), 32'(bus_a.out), 0);
      end
      en = 1'b0; clr_err = 1'b1;
      tick();
      chk("t1 clr err", 32'(bus_a.err), 0);
      clr_err = 1'b0;

      // Load the 6-state sequence
      wr(4'd0, 3'd2, 3'd2, 1'b1);  wr(4'd8, 3'd2, 3'd2, 1'b1);
      wr(4'd2, 3'd5, 3'd6, 1'b1);  wr(4'd10, 3'd5, 3'd6, 1'b1);
      wr(4'd3, 3'd6, 3'd5, 1'b1);  wr(4'd11, 3'd6, 3'd5, 1'b1);
      wr(4'd4, 3'd2, 3'd4, 1'b1);  wr(4'd12, 3'd2, 3'd4, 1'b1);
      wr(4'd6, 3'd4, 3'd6, 1'b1);  wr(4'd14, 3'd4, 3'd6, 1'b1);
      wr(4'd5, 3'd6, 3'd5, 1'b1);  wr(4'd13, 3'd3, 3'd5, 1'b1);
      chk("t2 hold state", 32'(bus_a.state), 0);

      en = 1'b1; in_v = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("t2 state[%0d]", i), 32'(bus_a.state), 32'(exp_s2[i]));
         chk($sformatf("t2 out_a[%0d]", i), 32'(bus_a.out), 32'(exp_o2[i]));
         chk($sformatf("t2 out_b[%0d]", i), 32'(bus_b.out), 32'(exp_ob2[i]));
         chk($sformatf("t2 cnt[%0d]", i), 32'(bus_a.trans_cnt), 32'(i));
         chk($sformatf("t2 cnt_c[%0d]", i), 32'(bus_c.trans_cnt), 32'(exp_c2[i]));
         if (i < 6) tick();
      end
      en = 1'b0;

      // in=1 branch: 5 goes to 3
      in_v = 1'b1; en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t3 state[%0d]", i), 32'(bus_a.state), 32'(exp_s3[i]));
         chk($sformatf("t3 out_a[%0d]", i), 32'(bus_a.out), 32'(exp_o3[i]));
         chk($sformatf("t3 err[%0d]", i), 32'(bus_a.err), 0);
         chk($sformatf("t3 cnt[%0d]", i), 32'(bus_a.trans_cnt), 32'(6 + i));
         chk($sformatf("t3 cnt_c[%0d]", i), 32'(bus_c.trans_cnt), 32'(exp_c3[i]));
         if (i < 5) tick();
      end

      // Rewrite {1,5} while stepping through it: old entry used this edge
      cfg_we = 1'b1; cfg_addr = 4'd13; cfg_next = 3'd4; cfg_out = 3'd7; cfg_valid = 1'b1;
      tick();
      cfg_we = 1'b0;
      chk("t4 old entry", 32'(bus_a.state), 3);
      chk("t4 cnt", 32'(bus_a.trans_cnt), 12);
      chk("t4 cnt_c", 32'(bus_c.trans_cnt), 0);
      repeat (4) tick();
      chk("t4 back at 5", 32'(bus_a.state), 5);
      chk("t4 new out", 32'(bus_a.out), 7);
      tick();
      chk("t4 new next", 32'(bus_a.state), 4);
      chk("t4 cnt2", 32'(bus_a.trans_cnt), 17);
      chk("t4 cnt_c2", 32'(bus_c.trans_cnt), 1);
      chk("t4 out at 4", 32'(bus_a.out), 4);

      // Self-loop at 4 and registered-output lag
      en = 1'b0;
      wr(4'd12, 3'd4, 3'd3, 1'b1);
      chk("t5 en0 hold", 32'(bus_a.state), 4);
      chk("t5 out_a new", 32'(bus_a.out), 3);
      chk("t5 out_b lag", 32'(bus_b.out), 4);
      en = 1'b1;
      repeat (4) tick();
      chk("t5 loop state", 32'(bus_a.state), 4);
      chk("t5 loop cnt", 32'(bus_a.trans_cnt), 17);
      chk("t5 loop out_b", 32'(bus_b.out), 3);
      chk("t5 loop state_b", 32'(bus_b.state), 4);

      // Invalidate and trap
      en = 1'b0;
      wr(4'd12, 3'd4, 3'd3, 1'b0);
      chk("t5 inv out", 32'(bus_a.out), 0);
      en = 1'b1;
      tick();
      chk("trap state", 32'(bus_a.state), 0);
      chk("trap err", 32'(bus_a.err), 1);
      chk("trap cnt", 32'(bus_a.trans_cnt), 17);
      en = 1'b0; clr_err = 1'b1;
      tick();
      chk("clr err", 32'(bus_a.err), 0);
      wr(4'd8, 3'd2, 3'd2, 1'b0);
      en = 1'b1;
      tick();
      chk("set wins err", 32'(bus_a.err), 1);
      chk("set wins state", 32'(bus_a.state), 0);
      clr_err = 1'b0;

      // Async reset mid-sequence discards the table
      in_v = 1'b0;
      tick();
      chk("t6 state", 32'(bus_a.state), 2);
      chk("t6 cnt_c", 32'(bus_c.trans_cnt), 2);
      chk("t6 err sticky", 32'(bus_a.err), 1);
      tick();
      chk("t6 state2", 32'(bus_a.state), 5);
      chk("t6 cnt_c2", 32'(bus_c.trans_cnt), 3);
      reset = 1'b0;
      #1;
      chk("t6 async state", 32'(bus_a.state), 0);
      chk("t6 async err", 32'(bus_a.err), 0);
      chk("t6 async cnt", 32'(bus_a.trans_cnt), 0);
      chk("t6 async cnt_c", 32'(bus_c.trans_cnt), 0);
      chk("t6 async out_b", 32'(bus_b.out), 0);
      chk("t6 async out_a", 32'(bus_a.out), 0);
      #1;
      reset = 1'b1;
      tick();
      chk("t6 post trap state", 32'(bus_a.state), 0);
      chk("t6 post trap err", 32'(bus_a.err), 1);
      chk("t6 post trap cnt", 32'(bus_a.trans_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/prog_table_fsm.md
Name: prog_table_fsm

Overview:
Table-driven, run-time-programmable finite state machine. It is the parametrised successor of the fixed 3-bit-state, 1-input ROM sequencer. State, input and output widths are set by parameters. Transition/output table is loaded through a config write port, entries carry a valid bit, illegal transitions are trapped with a sticky error, and a transition counter is provided. Used wherever a small sequencer/controller is needed without re-synthesising logic.

Parameters:
SW, 3, state width in bits; table holds 2^SW states
IW, 1, condition-input width in bits
OW, 3, output word width in bits
CW, 8, transition counter width
RESET_STATE, 0, state entered on reset and on illegal-entry trap (SW bits)
DEFAULT_OUT, 0, output value driven when current entry is invalid (OW bits)
REG_OUT, 0, 0 = out combinational from current entry (Mealy); 1 = out registered, one cycle later

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-low
en  in  1  step enable; state advances only when 1
in  in  IW  condition input
out  out  OW  output field of entry addressed by {in, state}, or DEFAULT_OUT
state  out  SW  current state register
err  out  1  sticky: an invalid entry was used for a step
clr_err  in  1  synchronous clear of err
cfg_we  in  1  table write strobe
cfg_addr  in  SW+IW  table address, {in, state} order (in = MSBs)
cfg_next  in  SW  next-state field to write
cfg_out  in  OW  output field to write
cfg_valid  in  1  valid bit to write
trans_cnt  out  CW  count of steps where next state != current state

Behaviour:
- Table: 2^(SW+IW) entries of {valid, next[SW], outv[OW]}. Address a = {in, state}.
- Reset (async, reset=0): state=RESET_STATE, err=0, trans_cnt=0, all valid bits=0, registered out (REG_OUT=1)=DEFAULT_OUT. next/outv fields not cleared.
- Current entry E = table[{in,state}]. Combinational out (REG_OUT=0) = E.valid ? E.outv : DEFAULT_OUT.
- REG_OUT=1: out register loads that same value every clock, independent of en.
- Rising edge with en=1 and E.valid=1: state <= E.next. If E.next != state, trans_cnt <= trans_cnt+1, wrapping modulo 2^CW.
- Rising edge with en=1 and E.valid=0: state <= RESET_STATE, err <= 1. trans_cnt unchanged.
- en=0: state and trans_cnt hold. err is affected only by clr_err.
- clr_err=1 clears err. If a trap occurs in the same cycle, set wins (err=1).
- cfg_we=1: table[cfg_addr] <= {cfg_valid, cfg_next, cfg_out} at the edge.
- Write to the currently addressed entry while en=1: this edge's step uses the OLD entry. The new content is visible from the next cycle. Combinational out changes only after the edge.
- No read-during-write bypass.
- Writing cfg_valid=0 invalidates an entry; a later step through it traps.
- Next-state values >= number of states used are legal; all 2^SW codes are addressable.
- Reset asserted mid-operation takes effect immediately and discards the whole table (all entries invalid). Software must reload after reset.
- Bench is responsible for 0-valued reset deassertion away from the clock edge.

Test Plan:
1. Reset, no writes, en=1, in=0, 3 clocks -> state=0, out=0, err=1 after first edge, trans_cnt=0. Then clr_err=1 for one clock with en=0 -> err=0.
2. Load 6-state sequence (SW=3, IW=1, OW=3), written for in=0 and in=1 except where noted:
   - 0->2 out2, 2->5 out6, 3->6 out5, 4->2 out4, 6->4 out6
   - 5: in=0 ->6 out5; in=1 ->3 out5
   Then en=1, in=0 -> states 0,2,5,6,4,2,5; outs 2,6,5,6,4,6,5; trans_cnt=6.
3. Same table, in=1 held -> states 0,2,5,3,6,4,2; at state 5 out=5 and next=3; err stays 0.
4. While in state 5, write addr {1,5} next=4 with en=1 and in=1 in the same cycle -> state goes to 3 (old entry). Re-visiting 5 with in=1 -> state 4.
5. REG_OUT=1 instance, step 0->2 -> out=2 appears one cycle after state=0 is first valid. Self-loop entry 2->2 for 4 clocks -> trans_cnt unchanged.
6. CW=2, 5 state-changing steps -> trans_cnt 1,2,3,0,1. Assert reset mid-sequence -> state=0 and err=0 immediately (async); next step traps (table invalidated).
